servo_pwm_driver: RTL and testbench

//  Drives the servo H-bridge from the signed output of the I-PD controller.

---
 rtl/servo_pkg.sv | 21 ++
 rtl/yk_sat_scale.sv | 34 +++
 rtl/servo_pwm_driver.sv | 138 +++++++++++++
 tb/tb_servo_pwm_driver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared defaults and FSM encoding for the servo H-bridge PWM driver.
package servo_pkg;

    localparam int unsigned CANT_BITS_DEF  = 13;
    localparam int unsigned SHIFT_DEF      = 10;
    localparam int unsigned PWM_BITS_DEF   = 11;
    localparam int unsigned PWM_PERIOD_DEF = 1000;
    localparam int unsigned DEAD_CYC_DEF   = 8;

    typedef enum logic [1:0] {
        S_FWD  = 2'd0,
        S_REV  = 2'd1,
        S_DEAD = 2'd2
    } pwm_state_e;

    // Bridge-leg state that drives a given direction bit.
    function automatic pwm_state_e leg_state(input logic dir);
        return dir ? S_REV : S_FWD;
    endfunction

endpackage

// File: rtl/yk_sat_scale.sv
// Combinational |Yk| >> SHIFT with saturation to PWM_PERIOD; reports sign and clip flag.
module yk_sat_scale
    import servo_pkg::*;
#(
    parameter int unsigned CANT_BITS  = CANT_BITS_DEF,
    parameter int unsigned SHIFT      = SHIFT_DEF,
    parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
    parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEF
) (
    input  logic [2*CANT_BITS-1:0] yk_i,
    output logic [PWM_BITS-1:0]    mag_o,
    output logic                   sign_o,
    output logic                   sat_o
);

    localparam int unsigned YW = 2 * CANT_BITS;
    localparam int unsigned AW = YW + 1;
    localparam logic [AW-1:0] PERIOD_W = AW'(PWM_PERIOD);

    logic [AW-1:0] yk_ext;
    logic [AW-1:0] abs_val;
    logic [AW-1:0] shifted;

    // One extra bit keeps the most negative Yk representable after negation.
    always_comb begin
        yk_ext  = {yk_i[YW-1], yk_i};
        abs_val = yk_i[YW-1] ? ((~yk_ext) + AW'(1)) : yk_ext;
        shifted = abs_val >> SHIFT;
        sat_o   = (shifted > PERIOD_W);
        mag_o   = sat_o ? PWM_BITS'(PWM_PERIOD) : shifted[PWM_BITS-1:0];
        sign_o  = yk_i[YW-1];
    end

endmodule

// File: rtl/servo_pwm_driver.sv
// Turns the signed IPD effort Yk into a period-shadowed duty/direction and a two-leg PWM.
// Optional: define PWM_DEADTIME_EN to hold both legs low for DEAD_CYC cycles on a reversal.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int unsigned CANT_BITS  = CANT_BITS_DEF,
    parameter int unsigned SHIFT      = SHIFT_DEF,
    parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
    parameter int unsigned PWM_PERIOD = PWM_PERIOD_DEF,
    parameter int unsigned DEAD_CYC   = DEAD_CYC_DEF
) (
    input  logic                   Clk_G,
    input  logic                   Rst_G,
    input  logic [2*CANT_BITS-1:0] Yk,
    input  logic                   Yk_En,
    output logic                   Pwm_A,
    output logic                   Pwm_B,
    output logic                   Dir,
    output logic [PWM_BITS-1:0]    Duty,
    output logic                   Sat,
    output logic                   Period_Tick
);

    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(PWM_PERIOD - 1);
`ifdef PWM_DEADTIME_EN
    localparam logic [PWM_BITS-1:0] DEAD_LAST = PWM_BITS'(DEAD_CYC - 1);
`endif

    if (PWM_PERIOD < 2 || PWM_PERIOD >= (1 << PWM_BITS) ||
        DEAD_CYC < 1 || DEAD_CYC >= PWM_PERIOD) begin : g_param_check
        $error("servo_pwm_driver: inconsistent PWM_PERIOD/PWM_BITS/DEAD_CYC");
    end

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] pend_duty_q, pend_duty_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pend_dir_q, pend_dir_d;
    logic                dir_q, dir_d;
    logic                sat_q, sat_d;
    logic                pwm_a_q, pwm_a_d;
    logic                pwm_b_q, pwm_b_d;
    pwm_state_e          state_q, state_d;

    logic                wrap;
    logic                pwm_on;
    logic [PWM_BITS-1:0] sc_mag;
    logic                sc_sign;
    logic                sc_sat;

    yk_sat_scale #(
        .CANT_BITS  (CANT_BITS),
        .SHIFT      (SHIFT),
        .PWM_BITS   (PWM_BITS),
        .PWM_PERIOD (PWM_PERIOD)
    ) u_scale (
        .yk_i   (Yk),
        .mag_o  (sc_mag),
        .sign_o (sc_sign),
        .sat_o  (sc_sat)
    );

    assign wrap = (cnt_q == CNT_LAST);

    // Capture and shadow share the wrap edge, so a strobe in the wrap cycle
    // lands in pending while active still takes the previous pending value.
    always_comb begin
        cnt_d       = wrap ? '0 : cnt_q + PWM_BITS'(1);
        pend_duty_d = pend_duty_q;
        pend_dir_d  = pend_dir_q;
        sat_d       = sat_q;
        duty_d      = duty_q;
        dir_d       = dir_q;
        if (Yk_En) begin
            pend_duty_d = sc_mag;
            pend_dir_d  = sc_sign;
            sat_d       = sc_sat;
        end
        if (wrap) begin
            duty_d = pend_duty_q;
            dir_d  = pend_dir_q;
        end
        pwm_on  = (cnt_q < duty_q);
        pwm_a_d = pwm_on && (state_q == S_FWD);
        pwm_b_d = pwm_on && (state_q == S_REV);
    end

    always_comb begin
        state_d = state_q;
        if (wrap) begin
`ifdef PWM_DEADTIME_EN
            if (state_q == S_DEAD || leg_state(pend_dir_q) == state_q) begin
                state_d = leg_state(pend_dir_q);
            end else begin
                state_d = S_DEAD;
            end
`else
            state_d = leg_state(pend_dir_q);
`endif
        end
`ifdef PWM_DEADTIME_EN
        else if (state_q == S_DEAD && cnt_q == DEAD_LAST) begin
            state_d = leg_state(dir_q);
        end
`endif
    end

    always_ff @(posedge Clk_G) begin
        if (Rst_G) begin
            cnt_q       <= '0;
            pend_duty_q <= '0;
            pend_dir_q  <= 1'b0;
            duty_q      <= '0;
            dir_q       <= 1'b0;
            sat_q       <= 1'b0;
            pwm_a_q     <= 1'b0;
            pwm_b_q     <= 1'b0;
            state_q     <= S_FWD;
        end else begin
            cnt_q       <= cnt_d;
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            sat_q       <= sat_d;
            pwm_a_q     <= pwm_a_d;
            pwm_b_q     <= pwm_b_d;
            state_q     <= state_d;
        end
    end

    assign Pwm_A       = pwm_a_q;
    assign Pwm_B       = pwm_b_q;
    assign Dir         = dir_q;
    assign Duty        = duty_q;
    assign Sat         = sat_q;
    assign Period_Tick = wrap;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Scoreboard bench for servo_pwm_driver: per-period expected records vs. a PWM monitor.
module tb_servo_pwm_driver;

    localparam int unsigned CB   = 13;
    localparam int unsigned PB   = 11;
    localparam int          PER  = 1000;
    localparam int          DEAD = 8;
`ifdef PWM_DEADTIME_EN
    localparam bit DEADTIME_ON = 1'b1;
`else
    localparam bit DEADTIME_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [2*CB-1:0] yk;
    logic          yk_en;
    logic          pwm_a, pwm_b, dir, sat, tick;
    logic [PB-1:0] duty;

    always #5 clk = ~clk;

    servo_pwm_driver #(
        .CANT_BITS  (CB),
        .SHIFT      (10),
        .PWM_BITS   (PB),
        .PWM_PERIOD (PER),
        .DEAD_CYC   (DEAD)
    ) dut (
        .Clk_G       (clk),
        .Rst_G       (rst),
        .Yk          (yk),
        .Yk_En       (yk_en),
        .Pwm_A       (pwm_a),
        .Pwm_B       (pwm_b),
        .Dir         (dir),
        .Duty        (duty),
        .Sat         (sat),
        .Period_Tick (tick)
    );

    typedef struct {
        int duty;
        int dir;
        int sat;
        int a_hi;
        int b_hi;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   tb_cnt    = 0;
    int   leg       = 0;

    task automatic check(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Bench timebase: position within the PWM period, restarted by reset.
    always @(posedge clk) tb_cnt <= rst ? 0 : ((tb_cnt == PER - 1) ? 0 : tb_cnt + 1);

    // Expected record for the period starting now; on-time loses dead cycles on a reversal.
    task automatic begin_period(input int e_duty, input int e_dir, input int e_sat);
        exp_t e;
        int   dead;
        dead = 0;
        if (DEADTIME_ON && e_dir != leg) dead = (e_duty < DEAD) ? e_duty : DEAD;
        leg    = e_dir;
        e.duty = e_duty;
        e.dir  = e_dir;
        e.sat  = e_sat;
        e.a_hi = e_dir ? 0 : e_duty - dead;
        e.b_hi = e_dir ? e_duty - dead : 0;
        exp_q.push_back(e);
    endtask

    task automatic step_to(input int k);
        do begin
            @(posedge clk);
            #1;
            yk_en = 1'b0;
        end while (tb_cnt != k);
    endtask

    task automatic strobe(input logic signed [2*CB-1:0] v, input int k);
        step_to(k);
        yk    = v;
        yk_en = 1'b1;
    endtask

    // Window for a period: samples from its cnt=1 through the next cnt=0 (one-cycle output lag).
    int   gap = 0, a_acc = 0, b_acc = 0;
    int   t_duty, t_dir, t_sat;
    bit   tick_seen = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            gap       = 0;
            a_acc     = 0;
            b_acc     = 0;
            tick_seen = 1'b0;
        end else begin
            gap++;
            a_acc += int'(pwm_a);
            b_acc += int'(pwm_b);
            if (pwm_a && pwm_b) check("legs_exclusive", 1, 0);
            if (tick_seen) begin
                tick_seen = 1'b0;
                check("record_available", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("duty", t_duty, e.duty);
                    check("dir", t_dir, e.dir);
                    check("sat", t_sat, e.sat);
                    check("pwm_a_high_cycles", a_acc, e.a_hi);
                    check("pwm_b_high_cycles", b_acc, e.b_hi);
                end
                a_acc = 0;
                b_acc = 0;
            end
            if (tick) begin
                check("tick_spacing", gap, PER);
                gap       = 0;
                tick_seen = 1'b1;
                t_duty    = int'(duty);
                t_dir     = int'(dir);
                t_sat     = int'(sat);
            end else if (gap > PER) begin
                check("tick_timeout", gap, PER);
                gap = 0;
            end
        end
    end

    initial begin
        rst   = 1'b1;
        yk_en = 1'b0;
        yk    = '0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_pwm_a", int'(pwm_a), 0);
        check("rst_pwm_b", int'(pwm_b), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_tick", int'(tick), 0);

        begin_period(0, 0, 0);    strobe(102400, 100);     step_to(0);
        begin_period(100, 0, 0);  strobe(-51200, 300);     step_to(0);
        begin_period(50, 1, 1);   strobe(33554431, 10);    step_to(0);
        begin_period(1000, 0, 1); strobe(-33554432, 500);  step_to(0);
        begin_period(1000, 1, 0); strobe(0, 200); strobe(102400, 999); step_to(0);
        begin_period(0, 0, 0);                             step_to(0);
        begin_period(100, 0, 0);  strobe(-51200, 100); strobe(204800, 600); step_to(0);
        begin_period(200, 0, 0);  strobe(716800, 50);      step_to(0);

        // Period with Duty=700 is cut short by a reset pulse at cnt=500.
        strobe(-33554432, 100);
        step_to(499);
        @(negedge clk);
        check("pre_rst_pwm_a", int'(pwm_a), 1);
        check("pre_rst_duty", int'(duty), 700);
        check("pre_rst_sat", int'(sat), 1);
        step_to(500);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        leg = 0;
        @(negedge clk);
        check("midrst_pwm_a", int'(pwm_a), 0);
        check("midrst_pwm_b", int'(pwm_b), 0);
        check("midrst_duty", int'(duty), 0);
        check("midrst_dir", int'(dir), 0);
        check("midrst_sat", int'(sat), 0);
        check("midrst_tick", int'(tick), 0);

        begin_period(0, 0, 0);    strobe(-51200, 20);      step_to(0);
        begin_period(50, 1, 0);   strobe(1025023, 100);    step_to(0);
        begin_period(1000, 0, 0);                          step_to(0);
        begin_period(1000, 0, 0);                          step_to(0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
